// File: rtl/countdown_timer.sv
// Preset hh:mm:ss countdown timer on the shared tick clock: load a duration, toggle
// run/pause on start_stop rising edges, count down once per second and flag expiry at zero.
module countdown_timer #(
    parameter int TICKS_PER_SECOND = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       load,
    input  logic [7:0] load_hours,
    input  logic [5:0] load_minutes,
    input  logic [5:0] load_seconds,
    output logic [7:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       expired,
    output logic       done_pulse
);

    localparam int PW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SECOND - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_EXPIRED
    } state_t;

    state_t        r_state, w_stateNext;
    logic [7:0]    r_hours, w_hoursNext;
    logic [5:0]    r_minutes, w_minutesNext;
    logic [5:0]    r_seconds, w_secondsNext;
    logic [PW-1:0] r_presc, w_prescNext;
    logic          r_ssQ;
    logic          r_done, w_doneNext;

    logic          w_rise;
    logic          w_timeZero;
    logic          w_lastSecond;

    assign w_rise       = start_stop & ~r_ssQ;
    assign w_timeZero   = (r_hours == 8'd0) && (r_minutes == 6'd0) && (r_seconds == 6'd0);
    assign w_lastSecond = (r_hours == 8'd0) && (r_minutes == 6'd0) && (r_seconds == 6'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_hours   <= 8'd0;
            r_minutes <= 6'd0;
            r_seconds <= 6'd0;
            r_presc   <= '0;
            r_ssQ     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_hours   <= w_hoursNext;
            r_minutes <= w_minutesNext;
            r_seconds <= w_secondsNext;
            r_presc   <= w_prescNext;
            r_ssQ     <= start_stop;
            r_done    <= w_doneNext;
        end
    end

    // A pausing rise wins over a coincident tick, leaving the prescaler at its last
    // value so the very first cycle after resume performs the lost decrement.
    always_comb begin
        w_stateNext   = r_state;
        w_hoursNext   = r_hours;
        w_minutesNext = r_minutes;
        w_secondsNext = r_seconds;
        w_prescNext   = r_presc;
        w_doneNext    = 1'b0;

        if (load) begin
            w_hoursNext   = (load_hours > 8'd99) ? 8'd99 : load_hours;
            w_minutesNext = (load_minutes > 6'd59) ? 6'd59 : load_minutes;
            w_secondsNext = (load_seconds > 6'd59) ? 6'd59 : load_seconds;
            w_prescNext   = '0;
            w_stateNext   = ST_IDLE;
        end else if (w_rise) begin
            if (r_state == ST_RUN) begin
                w_stateNext = ST_IDLE;
            end else if (!w_timeZero) begin
                w_stateNext = ST_RUN;
            end
        end else if (r_state == ST_RUN) begin
            if (r_presc != LAST_TICK) begin
                w_prescNext = r_presc + 1'b1;
            end else begin
                w_prescNext = '0;
                if (r_seconds != 6'd0) begin
                    w_secondsNext = r_seconds - 6'd1;
                end else begin
                    w_secondsNext = 6'd59;
                    if (r_minutes != 6'd0) begin
                        w_minutesNext = r_minutes - 6'd1;
                    end else begin
                        w_minutesNext = 6'd59;
                        w_hoursNext   = r_hours - 8'd1;
                    end
                end
                if (w_lastSecond) begin
                    w_stateNext = ST_EXPIRED;
                    w_doneNext  = 1'b1;
                end
            end
        end
    end

    assign hours      = r_hours;
    assign minutes    = r_minutes;
    assign seconds    = r_seconds;
    assign running    = (r_state == ST_RUN);
    assign expired    = (r_state == ST_EXPIRED);
    assign done_pulse = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a remaining-seconds model predicts every cycle,
// a monitor process pops predictions and compares them with the DUT outputs.
module tb_countdown_timer;

    localparam int TPS = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_hours = 8'd0;
    logic [5:0] load_minutes = 6'd0;
    logic [5:0] load_seconds = 6'd0;
    logic [7:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       expired;
    logic       done_pulse;

    always #5 clk = ~clk;

    countdown_timer #(.TICKS_PER_SECOND(TPS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_stop   (start_stop),
        .load         (load),
        .load_hours   (load_hours),
        .load_minutes (load_minutes),
        .load_seconds (load_seconds),
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .running      (running),
        .expired      (expired),
        .done_pulse   (done_pulse)
    );

    typedef struct {
        int h;
        int m;
        int s;
        bit run;
        bit exp;
        bit done;
    } expect_t;

    expect_t expQ[$];
    int testsRun = 0;
    int testsFailed = 0;
    int cycleNo = 0;

    // Reference model: remaining time held as a plain count of seconds.
    int mRem = 0;
    int mPresc = 0;
    bit mRun = 0;
    bit mExp = 0;
    bit mDone = 0;
    bit mSsPrev = 0;
    bit ssLevel = 0;

    task automatic modelStep(input bit rst, input bit ss, input bit ld,
                             input int h, input int m, input int s);
        bit rise;
        rise = ss && !mSsPrev;
        mSsPrev = rst ? 1'b0 : ss;
        mDone = 0;
        if (rst) begin
            mRem = 0; mPresc = 0; mRun = 0; mExp = 0;
        end else if (ld) begin
            mRem = ((h > 99) ? 99 : h) * 3600 + ((m > 59) ? 59 : m) * 60 + ((s > 59) ? 59 : s);
            mPresc = 0; mRun = 0; mExp = 0;
        end else if (rise) begin
            if (mRun) mRun = 0;
            else if (mRem != 0) mRun = 1;
        end else if (mRun) begin
            if (mPresc != TPS - 1) begin
                mPresc++;
            end else begin
                mPresc = 0;
                mRem--;
                if (mRem == 0) begin
                    mRun = 0; mExp = 1; mDone = 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ss, input bit ld,
                                 input int h, input int m, input int s);
        expect_t e;
        @(negedge clk);
        reset        = rst;
        start_stop   = ss;
        load         = ld;
        load_hours   = 8'(h);
        load_minutes = 6'(m);
        load_seconds = 6'(s);
        ssLevel      = ss;
        modelStep(rst, ss, ld, h & 255, m & 63, s & 63);
        e.h = mRem / 3600;
        e.m = (mRem / 60) % 60;
        e.s = mRem % 60;
        e.run = mRun;
        e.exp = mExp;
        e.done = mDone;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, ssLevel, 0, 0, 0, 0);
    endtask

    task automatic press();
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic loadTime(input int h, input int m, input int s);
        applyStimulus(0, ssLevel, 1, h, m, s);
    endtask

    task automatic checkOutput(input expect_t e);
        testsRun++;
        if (int'(hours) != e.h || int'(minutes) != e.m || int'(seconds) != e.s ||
            running != e.run || expired != e.exp || done_pulse != e.done) begin
            testsFailed++;
            $display("[TB] FAIL cycle%0d: got %0d:%0d:%0d run=%0b exp=%0b done=%0b, expected %0d:%0d:%0d run=%0b exp=%0b done=%0b",
                     cycleNo, hours, minutes, seconds, running, expired, done_pulse,
                     e.h, e.m, e.s, e.run, e.exp, e.done);
        end
    endtask

    // Monitor: every edge that had stimulus queued produces one comparison.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycleNo++;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        int r;
        $display("[TB] countdown_timer bench, TICKS_PER_SECOND=%0d", TPS);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset mid-count, then a rise at zero must be ignored.
        loadTime(0, 1, 30);
        press();
        idle(20);
        applyStimulus(1, 0, 0, 0, 0, 0);
        press();
        idle(5);

        // Basic countdown to expiry.
        loadTime(0, 0, 3);
        press();
        idle(35);

        // Borrow through minutes and hours.
        loadTime(1, 0, 0);
        press();
        idle(12);
        loadTime(0, 1, 0);
        press();
        idle(12);

        // Pause and resume, including pauses landing on tick cycles.
        loadTime(0, 0, 5);
        press();
        idle(15);
        press();
        idle(50);
        press();
        idle(10);
        for (int off = 0; off < 12; off++) begin
            loadTime(0, 0, 9);
            press();
            idle(off);
            press();
            idle(3);
            press();
            idle(3);
        end

        // Clamping, load beating a coincident rise, held start_stop.
        loadTime(150, 63, 63);
        idle(3);
        applyStimulus(0, 1, 1, 0, 0, 4);
        idle(5);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        idle(30);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Expiry hold, then reload and count again.
        loadTime(0, 0, 1);
        press();
        idle(15);
        press();
        idle(3);
        loadTime(0, 0, 2);
        idle(2);
        press();
        idle(25);

        // Randomized operation.
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) loadTime(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 63)));
            else if (r < 4) loadTime(int'($urandom_range(0, 255)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            else if (r < 5) applyStimulus(1, 0, 0, 0, 0, 0);
            else if (r < 11) applyStimulus(0, !ssLevel, 0, 0, 0, 0);
            else idle(1);
        end

        repeat (2) @(posedge clk);
        #2;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
